// File: rtl/bpsk_ask_demod.sv
// Coherent integrate-and-dump BPSK/ASK demodulator: multiply by reference, integrate SYM_LEN samples, decide.
// Optional PRBS (x^8+x^6+x^5+x^4+1) bit checker enabled by defining PRBS_CHECK_EN.
module bpsk_ask_demod #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SYM_LEN = 10000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ask_mode,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic signed [DATA_W-1:0] ref_carrier,
  input  logic signed [ACC_W-1:0]  ask_thresh,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic signed [ACC_W-1:0]  acc_out
`ifdef PRBS_CHECK_EN
  ,
  output logic [15:0]              err_cnt,
  output logic                     prbs_lock
`endif
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

  logic signed [PROD_W-1:0] p_q, p_d;
  logic                     p_vld_q, p_vld_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic                     bit_out_q, bit_out_d;
  logic                     bit_valid_q, bit_valid_d;
  logic signed [ACC_W-1:0]  sum_c;
  logic                     decision_c;

  // Multiply stage, then integrate-and-dump with the decision taken on the dump cycle
  always_comb begin
    p_d         = p_q;
    p_vld_d     = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    sum_c       = acc_q + ACC_W'(p_q);
    decision_c  = ask_mode ? (sum_c > ask_thresh) : sum_c[ACC_W-1];

    if (clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      p_vld_d = 1'b0;
    end else begin
      if (sample_en) begin
        p_d     = PROD_W'(in_sample) * PROD_W'(ref_carrier);
        p_vld_d = 1'b1;
      end
      if (p_vld_q) begin
        if (cnt_q == CNT_LAST) begin
          acc_d       = '0;
          cnt_d       = '0;
          acc_out_d   = sum_c;
          bit_out_d   = decision_c;
          bit_valid_d = 1'b1;
        end else begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign acc_out   = acc_out_q;

`ifdef PRBS_CHECK_EN
  localparam int unsigned LOCK_RUN = 16;

  logic [7:0]  s_q, s_d;
  logic [3:0]  fill_q, fill_d;
  logic [15:0] err_q, err_d;
  logic [4:0]  match_q, match_d;
  logic        lock_q, lock_d;
  logic        pred_c;

  // Predict each new bit from the previous eight; s_q[0] holds the most recent bit
  always_comb begin
    s_d     = s_q;
    fill_d  = fill_q;
    err_d   = err_q;
    match_d = match_q;
    lock_d  = lock_q;
    pred_c  = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];

    if (clr) begin
      s_d     = '0;
      fill_d  = '0;
      err_d   = '0;
      match_d = '0;
      lock_d  = 1'b0;
    end else if (bit_valid_q) begin
      s_d = {s_q[6:0], bit_out_q};
      if (fill_q < 4'd8) begin
        fill_d = fill_q + 4'd1;
      end else if (pred_c != bit_out_q) begin
        err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        match_d = '0;
        lock_d  = 1'b0;
      end else begin
        if (match_q < 5'(LOCK_RUN)) match_d = match_q + 5'd1;
        if (match_q >= 5'(LOCK_RUN - 1)) lock_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      fill_q  <= '0;
      err_q   <= '0;
      match_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      match_q <= match_d;
      lock_q  <= lock_d;
    end
  end

  assign err_cnt   = err_q;
  assign prbs_lock = lock_q;
`endif

endmodule

// File: doc/bpsk_ask_demod.md
Name: bpsk_ask_demod

Overview:
- Coherent integrate-and-dump demodulator for the 10 kbps ASK/PSK links.
- Multiplies incoming signed carrier samples by a locally generated reference carrier from the DDS, integrates over one symbol period, and decides one bit per symbol.
- Sits on the receive side, between the sample source and the bit sink or PRBS checker.

Parameters:
- DATA_W, 8, width of signed sample and reference inputs.
- ACC_W, 32, width of signed accumulator and dump output; must satisfy ACC_W >= 2*DATA_W + clog2(SYM_LEN).
- SYM_LEN, 10000, number of valid samples per symbol (10 kbps at 100 MS/s).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous re-align: restarts symbol framing.
- ask_mode  in  1  0 = PSK decision, 1 = ASK decision.
- sample_en  in  1  qualifies in_sample and ref_carrier this cycle.
- in_sample  in  DATA_W  signed received carrier sample.
- ref_carrier  in  DATA_W  signed local reference, phase-aligned.
- ask_thresh  in  ACC_W  signed ASK decision threshold; must be held stable.
- bit_out  out  1  decided bit; valid when bit_valid = 1, held otherwise.
- bit_valid  out  1  one-cycle strobe per decided symbol.
- acc_out  out  ACC_W  signed integrated value of the last symbol, held between dumps.

Behaviour:
- Reset (async, rst = 1): all registers clear to 0, including product register, product-valid flag, accumulator, symbol counter, bit_out, bit_valid, and acc_out.
- Stage 1 (multiply): when sample_en = 1, register p = in_sample * ref_carrier (signed, 2*DATA_W bits) and set p_vld = 1. Otherwise p_vld = 0.
- Stage 2 (accumulate), on each cycle with p_vld = 1:
  - sum = acc + sign_extend(p).
  - If cnt == SYM_LEN-1: acc <= 0, cnt <= 0, acc_out <= sum, bit_valid <= 1, bit_out <= decision(sum).
  - Else: acc <= sum, cnt <= cnt+1.
- bit_valid is 0 on every cycle except the cycle following a dump.
- Latency: bit_valid rises 2 clocks after the sample_en cycle carrying the SYM_LEN-th sample.
- Decision rules:
  - PSK (ask_mode = 0): bit = 1 iff sum < 0. The transmitter sends the inverted carrier for a 1.
  - ASK (ask_mode = 1): bit = 1 iff sum > ask_thresh (signed compare). sum == thresh gives 0.
- Gaps in sample_en: acc and cnt hold; a symbol always spans exactly SYM_LEN valid samples regardless of gaps.
- clr = 1 (synchronous, priority over everything except rst):
  - Clears acc, cnt, p_vld, and bit_valid.
  - A sample presented in the same cycle is discarded.
  - bit_out and acc_out hold their last values.
- clr mid-symbol: the partial symbol is discarded with no strobe.
- ask_mode is sampled at the dump cycle only; a change mid-symbol applies to the current symbol's decision.
- No saturation is needed: the worst case SYM_LEN*16384 fits ACC_W by construction.
- Counter width: clog2(SYM_LEN). The wrap at SYM_LEN-1 is the only wrap.

Optional Feature:
- Macro: PRBS_CHECK_EN.
- When defined, the block adds two outputs:
  - err_cnt (out, 16): saturates at 16'hFFFF.
  - prbs_lock (out, 1).
- Checker operation:
  - An 8-bit shift register s shifts in bit_out on each bit_valid.
  - Predicted bit = s[7]^s[5]^s[4]^s[3] (x^8+x^6+x^5+x^4+1, Fibonacci).
  - Comparison starts after 8 bits have been loaded.
  - A mismatch increments err_cnt and clears the match counter.
  - prbs_lock = 1 after 16 consecutive matches and drops on any mismatch.
  - rst and clr zero s, the fill count, err_cnt, the match counter, and prbs_lock.
- When not defined: these ports and all checker logic are absent; the core behaviour is identical.

Test Plan (SYM_LEN=4 override unless noted):
- PSK one: ask_mode=0, 4 samples in=100, ref=100, sample_en every cycle -> acc_out=40000, bit_out=0, bit_valid single pulse 2 clocks after 4th sample.
- PSK zero/one: in=-100, ref=100 ×4 -> acc_out=-40000, bit_out=1. Extremes in=-128, ref=-128 ×4 -> acc_out=65536, no overflow.
- ASK: ask_mode=1, ask_thresh=1000. in=0 ×4 -> acc_out=0, bit 0. in=20, ref=20 ×4 -> acc_out=1600, bit 1. Sum exactly 1000 -> bit 0.
- Gapped input: sample_en asserted every 3rd cycle, in=50, ref=50 -> acc_out=10000 after exactly 4 valid samples, strobe at the correct cycle.
- clr after 2 samples of a symbol, then 4 samples in=10, ref=10 -> no strobe for the partial symbol, then acc_out=400. Async rst mid-symbol -> all outputs 0 immediately.
- PRBS_CHECK_EN: feed a 40-symbol PSK sequence encoding the x^8+x^6+x^5+x^4+1 PRBS -> err_cnt=0, prbs_lock=1 after bit 24. Invert one symbol -> err_cnt increments and prbs_lock drops.
